// File: rtl/alu_defines.sv
// Shared ALU operator codes, RV32I opcode constants and the decoded-operation record.
// Used by the decode stage and by the ALU.
package alu_defines;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_XOR = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_AND = 4'b0100,
    ALU_SRA = 4'b0101,
    ALU_SRL = 4'b0110,
    ALU_SLL = 4'b0111,
    ALU_LTS = 4'b1000,
    ALU_LTU = 4'b1001,
    ALU_GES = 4'b1010,
    ALU_GEU = 4'b1011,
    ALU_EQ  = 4'b1100,
    ALU_NE  = 4'b1101
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e     op;
    logic [31:0] left;
    logic [31:0] right;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_branch;
    logic [31:0] branch_offset;
    logic        illegal;
  } decode_t;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32-entry register file: two combinational read ports, one write port,
// x0 reads as zero, and same-cycle write data bypassed onto the read ports.
module reg_file
  import alu_defines::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      addr_a,
  output logic [XLEN-1:0] data_a,
  input  logic [4:0]      addr_b,
  output logic [XLEN-1:0] data_b,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // The write lands at the same edge the reader samples, so pass it through early.
  always_comb begin
    data_a = '0;
    if (addr_a != 5'd0) begin
      data_a = (we && (waddr == addr_a)) ? wdata : regs[addr_a];
    end
  end

  always_comb begin
    data_b = '0;
    if (addr_b != 5'd0) begin
      data_b = (we && (waddr == addr_b)) ? wdata : regs[addr_b];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode of the incoming word into an ALU
// operation, captured in a one-entry output register with valid/ready handshake.
module decode_stage
  import alu_defines::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      out_operator,
  output logic [XLEN-1:0] out_left,
  output logic [XLEN-1:0] out_right,
  output logic [4:0]      out_rd,
  output logic            out_rd_we,
  output logic            out_is_branch,
  output logic [XLEN-1:0] out_branch_offset,
  output logic            out_illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  reg_file #(.XLEN(XLEN)) u_reg_file (
    .clk    (clk),
    .rst    (rst),
    .addr_a (rs1),
    .data_a (rs1_data),
    .addr_b (rs2),
    .data_b (rs2_data),
    .we     (wb_we),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  decode_t dec;
  logic    legal;

  always_comb begin
    dec   = '0;
    legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.left  = rs1_data;
        dec.right = rs2_data;
        dec.rd    = rd;
        dec.rd_we = 1'b1;
        legal     = 1'b1;
        case ({funct7, funct3})
          {F7_BASE, 3'b000}: dec.op = ALU_ADD;
          {F7_ALT,  3'b000}: dec.op = ALU_SUB;
          {F7_BASE, 3'b001}: dec.op = ALU_SLL;
          {F7_BASE, 3'b010}: dec.op = ALU_LTS;
          {F7_BASE, 3'b011}: dec.op = ALU_LTU;
          {F7_BASE, 3'b100}: dec.op = ALU_XOR;
          {F7_BASE, 3'b101}: dec.op = ALU_SRL;
          {F7_ALT,  3'b101}: dec.op = ALU_SRA;
          {F7_BASE, 3'b110}: dec.op = ALU_OR;
          {F7_BASE, 3'b111}: dec.op = ALU_AND;
          default:           legal  = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec.left  = rs1_data;
        dec.right = imm_i(in_instr);
        dec.rd    = rd;
        dec.rd_we = 1'b1;
        legal     = 1'b1;
        case (funct3)
          3'b000: dec.op = ALU_ADD;
          3'b010: dec.op = ALU_LTS;
          3'b011: dec.op = ALU_LTU;
          3'b100: dec.op = ALU_XOR;
          3'b110: dec.op = ALU_OR;
          3'b111: dec.op = ALU_AND;
          3'b001: begin
            dec.op    = ALU_SLL;
            dec.right = {27'b0, rs2};
            legal     = (funct7 == F7_BASE);
          end
          default: begin
            // funct3 101: funct7 picks logical vs arithmetic right shift
            dec.right = {27'b0, rs2};
            if (funct7 == F7_BASE) begin
              dec.op = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              dec.op = ALU_SRA;
            end else begin
              legal = 1'b0;
            end
          end
        endcase
      end
      OPC_BRANCH: begin
        dec.left          = rs1_data;
        dec.right         = rs2_data;
        dec.is_branch     = 1'b1;
        dec.branch_offset = imm_b(in_instr);
        legal             = 1'b1;
        case (funct3)
          3'b000:  dec.op = ALU_EQ;
          3'b001:  dec.op = ALU_NE;
          3'b100:  dec.op = ALU_LTS;
          3'b101:  dec.op = ALU_GES;
          3'b110:  dec.op = ALU_LTU;
          3'b111:  dec.op = ALU_GEU;
          default: legal  = 1'b0;
        endcase
      end
      OPC_LUI: begin
        dec.op    = ALU_ADD;
        dec.right = imm_u(in_instr);
        dec.rd    = rd;
        dec.rd_we = 1'b1;
        legal     = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // Illegal words leave a clean, side-effect-free operation behind.
    if (!legal) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  logic    out_valid_q;
  decode_t out_q;
  logic    accept;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_q       <= dec;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_operator      = out_q.op;
  assign out_left          = out_q.left;
  assign out_right         = out_q.right;
  assign out_rd            = out_q.rd;
  assign out_rd_we         = out_q.rd_we;
  assign out_is_branch     = out_q.is_branch;
  assign out_branch_offset = out_q.branch_offset;
  assign out_illegal       = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic checked
// against a cycle-level reference model of the handshake, register file and decode.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_operator;
  logic [31:0] out_left;
  logic [31:0] out_right;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic        out_is_branch;
  logic [31:0] out_branch_offset;
  logic        out_illegal;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_instr          (in_instr),
    .wb_we             (wb_we),
    .wb_addr           (wb_addr),
    .wb_data           (wb_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_operator      (out_operator),
    .out_left          (out_left),
    .out_right         (out_right),
    .out_rd            (out_rd),
    .out_rd_we         (out_rd_we),
    .out_is_branch     (out_is_branch),
    .out_branch_offset (out_branch_offset),
    .out_illegal       (out_illegal)
  );

  typedef struct {
    logic [3:0]  op;
    logic [31:0] left;
    logic [31:0] right;
    logic [4:0]  rd;
    logic        rd_we;
    logic        br;
    logic [31:0] off;
    logic        ill;
  } exp_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Operator per funct3 for register/immediate ALU ops and for branches (-1 = no such form).
  int op_tab[8] = '{0, 7, 8, 9, 2, 6, 3, 4};
  int br_tab[8] = '{12, 13, -1, -1, 8, 10, 9, 11};

  logic [31:0] rf [32];
  exp_t        m;
  bit          m_valid;
  bit          m_cmp_all;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t zero_exp();
    exp_t e;
    e.op = 4'd0; e.left = 32'd0; e.right = 32'd0; e.rd = 5'd0;
    e.rd_we = 1'b0; e.br = 1'b0; e.off = 32'd0; e.ill = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] read_reg(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_addr == a) return wb_data;
    return rf[a];
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] ins);
    exp_t        e;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a, b, imm;
    int          off;
    bit          ok;
    e   = zero_exp();
    f3  = ins[14:12];
    f7  = ins[31:25];
    a   = read_reg(ins[19:15]);
    b   = read_reg(ins[24:20]);
    imm = 32'($signed(ins) >>> 20);
    ok  = 1'b0;
    case (ins[6:0])
      7'h33: begin
        e.left = a; e.right = b; e.rd = ins[11:7]; e.rd_we = 1'b1;
        if (f7 == 7'h00) begin ok = 1'b1; e.op = 4'(op_tab[f3]); end
        else if (f7 == 7'h20 && f3 == 3'd0) begin ok = 1'b1; e.op = 4'd1; end
        else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; e.op = 4'd5; end
      end
      7'h13: begin
        e.left = a; e.rd = ins[11:7]; e.rd_we = 1'b1;
        if (f3 == 3'd1 || f3 == 3'd5) begin
          e.right = 32'(ins[24:20]);
          if (f7 == 7'h00) begin ok = 1'b1; e.op = 4'(op_tab[f3]); end
          else if (f7 == 7'h20 && f3 == 3'd5) begin ok = 1'b1; e.op = 4'd5; end
        end else begin
          ok = 1'b1; e.right = imm; e.op = 4'(op_tab[f3]);
        end
      end
      7'h63: begin
        e.left = a; e.right = b; e.br = 1'b1;
        off = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
              + int'(ins[11:8]) * 2;
        e.off = 32'(off);
        if (br_tab[f3] >= 0) begin ok = 1'b1; e.op = 4'(br_tab[f3]); end
      end
      7'h37: begin
        ok = 1'b1; e.op = 4'd0; e.right = ins & 32'hFFFF_F000;
        e.rd = ins[11:7]; e.rd_we = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = zero_exp();
      e.ill = 1'b1;
    end
    return e;
  endfunction

  // One clock: inputs are already driven; check in_ready, advance the model, check outputs.
  task automatic tick();
    bit rdy;
    #3;
    rdy = !m_valid || out_ready;
    check("in_ready", {31'd0, in_ready}, {31'd0, rdy});
    if (rst) begin
      m         = zero_exp();
      m_valid   = 1'b0;
      m_cmp_all = 1'b1;
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    end else begin
      m_cmp_all = 1'b0;
      if (in_valid && rdy) begin
        m       = ref_decode(in_instr);
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      if (wb_we && wb_addr != 5'd0) rf[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    if (m_valid || m_cmp_all) begin
      check("operator", {28'd0, out_operator}, {28'd0, m.op});
      check("left", out_left, m.left);
      check("right", out_right, m.right);
      check("rd", {27'd0, out_rd}, {27'd0, m.rd});
      check("rd_we", {31'd0, out_rd_we}, {31'd0, m.rd_we});
      check("is_branch", {31'd0, out_is_branch}, {31'd0, m.br});
      check("branch_offset", out_branch_offset, m.off);
      check("illegal", {31'd0, out_illegal}, {31'd0, m.ill});
    end
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input bit ordy,
                       input bit we, input logic [4:0] wa, input logic [31:0] wd);
    in_valid  = v;
    in_instr  = ins;
    out_ready = ordy;
    wb_we     = we;
    wb_addr   = wa;
    wb_data   = wd;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins;
    int          sel;
    ins = $urandom;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2: ins[6:0] = 7'h33;
      3, 4, 5: ins[6:0] = 7'h13;
      6, 7:    ins[6:0] = 7'h63;
      8:       ins[6:0] = 7'h37;
      default: ins[6:0] = 7'($urandom);
    endcase
    case ($urandom_range(0, 3))
      0, 1:    ins[31:25] = 7'h00;
      2:       ins[31:25] = 7'h20;
      default: ins[31:25] = 7'($urandom);
    endcase
    ins[19:15] = 5'($urandom_range(0, 7));
    if (ins[6:0] != 7'h13) ins[24:20] = 5'($urandom_range(0, 7));
    return ins;
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    m         = zero_exp();
    m_valid   = 1'b0;
    m_cmp_all = 1'b0;
    rst = 1'b1;
    drive(0, 32'd0, 1, 0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    tick();
    rst = 1'b0;
    check("reset_ready", {31'd0, in_ready}, 32'd1);

    // SUB x7,x5,x6 with x5=10, x6=3
    drive(0, 32'd0, 1, 1, 5'd5, 32'h0000_000A); tick();
    drive(0, 32'd0, 1, 1, 5'd6, 32'd3);         tick();
    drive(1, 32'h4062_83B3, 1, 0, 5'd0, 32'd0); tick();
    check("sub_op", {28'd0, out_operator}, 32'd1);
    check("sub_left", out_left, 32'hA);
    check("sub_right", out_right, 32'd3);
    check("sub_rd", {27'd0, out_rd}, 32'd7);

    // ADDI x1,x0,-1
    drive(1, 32'hFFF0_0093, 1, 0, 5'd0, 32'd0); tick();
    check("addi_right", out_right, 32'hFFFF_FFFF);
    check("addi_rd", {27'd0, out_rd}, 32'd1);

    // SRAI x2,x1,4 with x1=0x80000000
    drive(0, 32'd0, 1, 1, 5'd1, 32'h8000_0000); tick();
    drive(1, 32'h4040_D113, 1, 0, 5'd0, 32'd0); tick();
    check("srai_op", {28'd0, out_operator}, 32'd5);
    check("srai_left", out_left, 32'h8000_0000);
    check("srai_right", out_right, 32'd4);

    // Stall for two cycles, then the waiting ADDI goes in as out_ready rises.
    drive(1, 32'h4062_83B3, 1, 0, 5'd0, 32'd0); tick();
    drive(1, 32'hFFF0_0093, 0, 0, 5'd0, 32'd0); tick();
    check("stall_ready", {31'd0, in_ready}, 32'd0);
    check("stall_hold", {28'd0, out_operator}, 32'd1);
    tick();
    check("stall_hold2", out_right, 32'd3);
    drive(1, 32'hFFF0_0093, 1, 0, 5'd0, 32'd0); tick();
    check("after_stall_op", {28'd0, out_operator}, 32'd0);
    check("after_stall_rd", {27'd0, out_rd}, 32'd1);

    // Same-cycle writeback bypass: ADD x7,x5,x0 while writing x5
    drive(1, 32'h0002_83B3, 1, 1, 5'd5, 32'h0000_1234); tick();
    check("bypass_left", out_left, 32'h1234);
    drive(1, 32'h0000_0000, 1, 0, 5'd0, 32'd0); tick();
    check("zero_illegal", {31'd0, out_illegal}, 32'd1);
    check("zero_rd_we", {31'd0, out_rd_we}, 32'd0);

    // Writeback alone must not disturb a held operation.
    drive(1, 32'h0002_83B3, 1, 0, 5'd0, 32'd0); tick();
    drive(0, 32'd0, 0, 1, 5'd5, 32'hDEAD_BEEF); tick();
    check("wb_no_update", out_left, 32'h1234);

    // Reset in the middle of a stall
    drive(1, 32'h4062_83B3, 0, 0, 5'd0, 32'd0); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    check("rst_stall_valid", {31'd0, out_valid}, 32'd0);
    check("rst_stall_ready", {31'd0, in_ready}, 32'd1);

    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
